seg_disp_ctrl: RTL and testbench

- Display refresh controller that sits directly upstream of the 7-segment serial display device. It drives that device's Hexs, point, LES, Start and flash inputs.
- Accepts 32-bit display words from the CPU/IO bus into a shadow register, then copies them atomically into the display registers.
- Issues a one-cycle Start per frame and waits for the serializer to finish, observed as a rising edge on its SEG_PEN output.
- Also refreshes periodically and generates the blink clock.

---
 rtl/seg_disp_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg_disp_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_ctrl.sv
// Refresh controller for the 7-segment serial display: shadow-buffers bus writes and sends frames.
// Optional macro SEG_FRAME_CNT_EN adds a 16-bit count of frames the serializer completed.
module seg_disp_ctrl #(
    parameter int REFRESH_CYC = 1000000,
    parameter int FLASH_DIV   = 25000000,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_point,
    input  logic [7:0]  wr_les,
    input  logic        seg_pen,
    output logic [31:0] Hexs,
    output logic [7:0]  point,
    output logic [7:0]  LES,
    output logic        Start,
    output logic        flash,
    output logic        busy,
    output logic        timeout_err
`ifdef SEG_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT} state_t;

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]     FLASH_LAST = 32'(FLASH_DIV - 1);

    state_t            state_q, state_d;
    logic [31:0]       shadow_hex_q;
    logic [7:0]        shadow_point_q, shadow_les_q;
    logic [31:0]       hexs_q;
    logic [7:0]        point_q, les_q;
    logic              pending_q, pending_d;
    logic              seg_pen_prev_q;
    logic              pen_rise;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              load;
    logic              refresh_tick;
    logic              flash_tick;
    logic              flash_q;
    logic [31:0]       flash_cnt_q;

    assign pen_rise   = seg_pen & ~seg_pen_prev_q;
    assign flash_tick = (flash_cnt_q == FLASH_LAST);

    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
        load          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (pen_rise) begin
                    state_d = ST_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A set in the LOAD cycle beats the clear, so a write racing LOAD goes out next frame.
    always_comb begin
        pending_d = pending_q;
        if (load) pending_d = 1'b0;
        if (wr_en || refresh_tick || flash_tick) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            shadow_hex_q   <= '0;
            shadow_point_q <= '0;
            shadow_les_q   <= '0;
            hexs_q         <= '0;
            point_q        <= '0;
            les_q          <= '0;
            pending_q      <= 1'b1;
            seg_pen_prev_q <= 1'b1;
            to_cnt_q       <= '0;
            timeout_err_q  <= 1'b0;
            flash_q        <= 1'b0;
            flash_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            seg_pen_prev_q <= seg_pen;
            to_cnt_q       <= to_cnt_d;
            timeout_err_q  <= timeout_err_d;
            if (wr_en) begin
                shadow_hex_q   <= wr_data;
                shadow_point_q <= wr_point;
                shadow_les_q   <= wr_les;
            end
            if (load) begin
                hexs_q  <= shadow_hex_q;
                point_q <= shadow_point_q;
                les_q   <= shadow_les_q;
            end
            if (flash_tick) begin
                flash_cnt_q <= '0;
                flash_q     <= ~flash_q;
            end else begin
                flash_cnt_q <= flash_cnt_q + 32'd1;
            end
        end
    end

    // REFRESH_CYC of zero removes the periodic refresh entirely.
    generate
        if (REFRESH_CYC > 0) begin : g_refresh
            localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYC - 1);
            logic [31:0] refresh_cnt_q;
            assign refresh_tick = (refresh_cnt_q == REFRESH_LAST);
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    refresh_cnt_q <= '0;
                end else if (refresh_tick) begin
                    refresh_cnt_q <= '0;
                end else begin
                    refresh_cnt_q <= refresh_cnt_q + 32'd1;
                end
            end
        end else begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end
    endgenerate

`ifdef SEG_FRAME_CNT_EN
    logic        frame_done;
    logic [15:0] frame_cnt_q;
    assign frame_done = (state_q == ST_WAIT) && pen_rise;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end
    assign frame_cnt = frame_cnt_q;
`endif

    assign Hexs        = hexs_q;
    assign point       = point_q;
    assign LES         = les_q;
    assign Start       = (state_q == ST_START);
    assign busy        = (state_q != ST_IDLE);
    assign flash       = flash_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl: three instances cover long-timeout, short-timeout and periodic refresh.
module tb_seg_disp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, seg_pen, seg_pen_per;
    logic [31:0] wr_data;
    logic [7:0]  wr_point, wr_les;

    logic [31:0] d_hexs, t_hexs, p_hexs;
    logic [7:0]  d_point, t_point, p_point, d_les, t_les, p_les;
    logic        d_start, d_flash, d_busy, d_err;
    logic        t_start, t_flash, t_busy, t_err;
    logic        p_start, p_flash, p_busy, p_err;
`ifdef SEG_FRAME_CNT_EN
    logic [15:0] d_fcnt, t_fcnt, p_fcnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    seg_disp_ctrl #(.REFRESH_CYC(0), .FLASH_DIV(1000000), .TIMEOUT_CYC(32)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_point(wr_point),
        .wr_les(wr_les), .seg_pen(seg_pen), .Hexs(d_hexs), .point(d_point), .LES(d_les),
        .Start(d_start), .flash(d_flash), .busy(d_busy), .timeout_err(d_err)
`ifdef SEG_FRAME_CNT_EN
        , .frame_cnt(d_fcnt)
`endif
    );

    seg_disp_ctrl #(.REFRESH_CYC(0), .FLASH_DIV(1000000), .TIMEOUT_CYC(8)) u_to (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_point(wr_point),
        .wr_les(wr_les), .seg_pen(seg_pen), .Hexs(t_hexs), .point(t_point), .LES(t_les),
        .Start(t_start), .flash(t_flash), .busy(t_busy), .timeout_err(t_err)
`ifdef SEG_FRAME_CNT_EN
        , .frame_cnt(t_fcnt)
`endif
    );

    seg_disp_ctrl #(.REFRESH_CYC(50), .FLASH_DIV(100), .TIMEOUT_CYC(8)) u_per (
        .clk(clk), .rst(rst), .wr_en(1'b0), .wr_data(32'h0), .wr_point(8'h0),
        .wr_les(8'h0), .seg_pen(seg_pen_per), .Hexs(p_hexs), .point(p_point), .LES(p_les),
        .Start(p_start), .flash(p_flash), .busy(p_busy), .timeout_err(p_err)
`ifdef SEG_FRAME_CNT_EN
        , .frame_cnt(p_fcnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Write strobe sampled at the next edge; returns just after that edge.
    task automatic do_write(input logic [31:0] d, input logic [7:0] p, input logic [7:0] l);
        wr_en    = 1'b1;
        wr_data  = d;
        wr_point = p;
        wr_les   = l;
        tick();
        wr_en    = 1'b0;
        $display("write data=%h point=%h les=%h", d, p, l);
    endtask

    task automatic finish_frame;
        seg_pen = 1'b0;
        tick();
        seg_pen = 1'b1;
        tick();
        seg_pen = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; wr_en = 1'b0; seg_pen = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({d_hexs, d_point, d_les} !== 48'h0) begin
            n_fail++; $display("FAIL reset_disp: got %h want 0", {d_hexs, d_point, d_les});
        end
        n_checks++;
        if ({d_start, d_flash, d_busy, d_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 0000", {d_start, d_flash, d_busy, d_err});
        end
        @(negedge clk) rst = 1'b1;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            tick();
            n_checks++;
            if (d_start !== (cyc == 2)) begin
                n_fail++; $display("FAIL reset_frame_start c%0d: got %b want %b", cyc, d_start, cyc == 2);
            end
            n_checks++;
            if (d_busy !== (cyc <= 19)) begin
                n_fail++; $display("FAIL reset_frame_busy c%0d: got %b want %b", cyc, d_busy, cyc <= 19);
            end
            if (cyc == 2) begin
                n_checks++;
                if (d_hexs !== 32'h0) begin
                    n_fail++; $display("FAIL reset_frame_hexs: got %h want 0", d_hexs);
                end
            end
            if (cyc == 19) seg_pen = 1'b1;
        end
        seg_pen = 1'b0;
        $display("reset frame done");
    endtask

    task automatic test_write;
        do_write(32'h12345678, 8'h0F, 8'h00);
        n_checks++;
        if ({d_start, d_busy} !== 2'b00) begin
            n_fail++; $display("FAIL write_k: got %b want 00", {d_start, d_busy});
        end
        tick();
        n_checks++;
        if ({d_start, d_busy} !== 2'b01) begin
            n_fail++; $display("FAIL write_k1: got %b want 01", {d_start, d_busy});
        end
        tick();
        n_checks++;
        if ({d_start, d_hexs, d_point, d_les} !== {1'b1, 32'h12345678, 8'h0F, 8'h00}) begin
            n_fail++; $display("FAIL write_k2: got %b %h %h %h want 1 12345678 0f 00", d_start, d_hexs, d_point, d_les);
        end
        tick();
        n_checks++;
        if ({d_start, d_hexs} !== {1'b0, 32'h12345678}) begin
            n_fail++; $display("FAIL write_k3: got %b %h want 0 12345678", d_start, d_hexs);
        end
        seg_pen = 1'b1;
        tick();
        n_checks++;
        if (d_busy !== 1'b0) begin
            n_fail++; $display("FAIL write_done_busy: got %b want 0", d_busy);
        end
        seg_pen = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        int starts;
        do_write(32'hC0DE0001, 8'h01, 8'h02);
        tick();
        tick();
        n_checks++;
        if ({d_start, d_hexs} !== {1'b1, 32'hC0DE0001}) begin
            n_fail++; $display("FAIL b2b_first: got %b %h want 1 c0de0001", d_start, d_hexs);
        end
        tick();
        do_write(32'hAAAA0000, 8'h11, 8'h22);
        n_checks++;
        if ({d_busy, d_hexs} !== {1'b1, 32'hC0DE0001}) begin
            n_fail++; $display("FAIL b2b_wait1: got %b %h want 1 c0de0001", d_busy, d_hexs);
        end
        do_write(32'hBBBB1111, 8'hF0, 8'h0F);
        n_checks++;
        if ({d_hexs, d_point} !== {32'hC0DE0001, 8'h01}) begin
            n_fail++; $display("FAIL b2b_wait2: got %h %h want c0de0001 01", d_hexs, d_point);
        end
        tick();
        tick();
        n_checks++;
        if ({d_start, d_hexs} !== {1'b0, 32'hC0DE0001}) begin
            n_fail++; $display("FAIL b2b_hold: got %b %h want 0 c0de0001", d_start, d_hexs);
        end
        seg_pen = 1'b1;
        starts = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (d_start === 1'b1) begin
                starts++;
                n_checks++;
                if ({d_hexs, d_point, d_les} !== {32'hBBBB1111, 8'hF0, 8'h0F}) begin
                    n_fail++; $display("FAIL b2b_next: got %h %h %h want bbbb1111 f0 0f", d_hexs, d_point, d_les);
                end
            end
        end
        n_checks++;
        if (starts !== 1) begin
            n_fail++; $display("FAIL b2b_starts: got %0d want 1", starts);
        end
        finish_frame();
        n_checks++;
        if ({d_busy, d_err} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_end: got %b want 00", {d_busy, d_err});
        end
    endtask

    task automatic test_write_during_load;
        do_write(32'h11112222, 8'h33, 8'h44);
        tick();
        do_write(32'h55556666, 8'h77, 8'h88);
        n_checks++;
        if ({d_start, d_hexs, d_point} !== {1'b1, 32'h11112222, 8'h33}) begin
            n_fail++; $display("FAIL load_race_old: got %b %h %h want 1 11112222 33", d_start, d_hexs, d_point);
        end
        finish_frame();
        n_checks++;
        if (d_busy !== 1'b0) begin
            n_fail++; $display("FAIL load_race_idle: got %b want 0", d_busy);
        end
        tick();
        n_checks++;
        if (d_busy !== 1'b1) begin
            n_fail++; $display("FAIL load_race_pending: got %b want 1", d_busy);
        end
        tick();
        n_checks++;
        if ({d_start, d_hexs, d_les} !== {1'b1, 32'h55556666, 8'h88}) begin
            n_fail++; $display("FAIL load_race_new: got %b %h %h want 1 55556666 88", d_start, d_hexs, d_les);
        end
        finish_frame();
        n_checks++;
        if (d_busy !== 1'b0) begin
            n_fail++; $display("FAIL load_race_end: got %b want 0", d_busy);
        end
    endtask

    task automatic test_timeout;
        rst = 1'b0; seg_pen = 1'b0;
        repeat (2) tick();
        @(negedge clk) rst = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            n_checks++;
            if ({t_busy, t_err} !== {cyc <= 10, cyc >= 11}) begin
                n_fail++; $display("FAIL timeout c%0d: got busy/err %b want %b", cyc, {t_busy, t_err}, {cyc <= 10, cyc >= 11});
            end
        end
        do_write(32'h0000BEEF, 8'h01, 8'h01);
        tick();
        tick();
        n_checks++;
        if ({t_start, t_hexs} !== {1'b1, 32'h0000BEEF}) begin
            n_fail++; $display("FAIL timeout_good: got %b %h want 1 0000beef", t_start, t_hexs);
        end
        finish_frame();
        n_checks++;
        if ({t_busy, t_err} !== 2'b01) begin
            n_fail++; $display("FAIL timeout_sticky: got %b want 01", {t_busy, t_err});
        end
        do_write(32'h0000CAFE, 8'h02, 8'h02);
        tick();
        tick();
        n_checks++;
        if ({t_start, t_err} !== 2'b11) begin
            n_fail++; $display("FAIL timeout_second: got %b want 11", {t_start, t_err});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({t_start, t_busy, t_err, t_hexs} !== {3'b000, 32'h0}) begin
            n_fail++; $display("FAIL async_reset: got %b %h want 000 0", {t_start, t_busy, t_err}, t_hexs);
        end
        tick();
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

`ifdef SEG_FRAME_CNT_EN
    task automatic test_frame_cnt;
        rst = 1'b0; seg_pen = 1'b0;
        tick();
        n_checks++;
        if (t_fcnt !== 16'd0) begin
            n_fail++; $display("FAIL fcnt_reset: got %0d want 0", t_fcnt);
        end
        @(negedge clk) rst = 1'b1;
        repeat (12) tick();
        n_checks++;
        if ({t_err, t_fcnt} !== {1'b1, 16'd0}) begin
            n_fail++; $display("FAIL fcnt_timeout: got %b %0d want 1 0", t_err, t_fcnt);
        end
        for (int i = 0; i < 3; i++) begin
            do_write(32'h00000100 + i, 8'h00, 8'h00);
            tick();
            tick();
            finish_frame();
        end
        n_checks++;
        if (t_fcnt !== 16'd3) begin
            n_fail++; $display("FAIL fcnt_three: got %0d want 3", t_fcnt);
        end
        do_write(32'h00000200, 8'h00, 8'h00);
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({t_fcnt, t_start, t_busy} !== {16'd0, 2'b00}) begin
            n_fail++; $display("FAIL fcnt_async_reset: got %0d %b want 0 00", t_fcnt, {t_start, t_busy});
        end
        tick();
        @(negedge clk) rst = 1'b1;
        tick();
    endtask
`endif

    task automatic test_periodic;
        int starts, toggles, followed, first_toggle, last_toggle;
        logic prev_flash;
        starts = 0; toggles = 0; followed = 0; first_toggle = 0; last_toggle = -100;
        rst = 1'b0;
        tick();
        prev_flash = p_flash;
        @(negedge clk) rst = 1'b1;
        for (int cyc = 1; cyc <= 1010; cyc++) begin
            tick();
            if (p_start === 1'b1) begin
                starts++;
                if (cyc - last_toggle == 2) followed++;
            end
            if (p_flash !== prev_flash) begin
                toggles++;
                if (first_toggle == 0) first_toggle = cyc;
                last_toggle = cyc;
                prev_flash = p_flash;
            end
        end
        $display("periodic: starts=%0d toggles=%0d followed=%0d", starts, toggles, followed);
        n_checks++;
        if (starts !== 21) begin
            n_fail++; $display("FAIL periodic_starts: got %0d want 21", starts);
        end
        n_checks++;
        if (toggles !== 10) begin
            n_fail++; $display("FAIL flash_toggles: got %0d want 10", toggles);
        end
        n_checks++;
        if (first_toggle !== 100) begin
            n_fail++; $display("FAIL flash_first: got %0d want 100", first_toggle);
        end
        n_checks++;
        if (followed !== 10) begin
            n_fail++; $display("FAIL flash_start: got %0d want 10", followed);
        end
        n_checks++;
        if (p_flash !== 1'b0) begin
            n_fail++; $display("FAIL flash_level: got %b want 0", p_flash);
        end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; seg_pen = 1'b0; seg_pen_per = 1'b0;
        wr_data = '0; wr_point = '0; wr_les = '0;
        test_reset();
        test_write();
        test_back_to_back();
        test_write_during_load();
        n_checks++;
        if (d_err !== 1'b0) begin
            n_fail++; $display("FAIL no_timeout: got %b want 0", d_err);
        end
        test_timeout();
`ifdef SEG_FRAME_CNT_EN
        test_frame_cnt();
`endif
        test_periodic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
